// File: rtl/stage_d_issue.sv
// Decode/issue stage of a dual-issue in-order pipeline: holds the fetched
// instruction pair, detects intra-pair hazards and emits a registered issue packet.
module stage_d_issue #(
    parameter int                 DATA_W = 32,
    parameter int                 PC_W   = 15,
    parameter logic [DATA_W-1:0]  NOP    = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              w_miss,
    input  logic [PC_W-1:0]   w_pc1,
    input  logic [PC_W-1:0]   w_pc2,
    input  logic [DATA_W-1:0] instruction1,
    input  logic [DATA_W-1:0] instruction2,
    output logic [PC_W-1:0]   F_D_pc1,
    output logic [PC_W-1:0]   F_D_pc2,
    output logic              next_is_single,
    output logic [PC_W-1:0]   D_pc1,
    output logic [PC_W-1:0]   D_pc2,
    output logic [DATA_W-1:0] D_ir1,
    output logic [DATA_W-1:0] D_ir2,
    output logic              D_valid1,
    output logic              D_valid2,
    output logic [15:0]       n_single,
    output logic [15:0]       n_dual
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic reads_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    logic              fd_valid_q, fd_valid_d;
    logic [PC_W-1:0]   fd_pc1_q, fd_pc1_d;
    logic [PC_W-1:0]   fd_pc2_q, fd_pc2_d;
    logic [PC_W-1:0]   iss_pc1_q, iss_pc1_d;
    logic [PC_W-1:0]   iss_pc2_q, iss_pc2_d;
    logic [DATA_W-1:0] iss_ir1_q, iss_ir1_d;
    logic [DATA_W-1:0] iss_ir2_q, iss_ir2_d;
    logic              iss_vld1_q, iss_vld1_d;
    logic              iss_vld2_q, iss_vld2_d;
    logic [15:0]       n_single_q, n_single_d;
    logic [15:0]       n_dual_q, n_dual_d;

    logic [6:0] op1, op2;
    logic [4:0] rd1, rs1_2, rs2_2;
    logic       raw_hazard;
    logic       pair_hazard;
    logic       single;

    // Hazard detection on the pair currently presented by instruction memory
    always_comb begin
        op1         = instruction1[6:0];
        op2         = instruction2[6:0];
        rd1         = instruction1[11:7];
        rs1_2       = instruction2[19:15];
        rs2_2       = instruction2[24:20];
        raw_hazard  = (rd1 != 5'd0) &&
                      ((reads_rs1(op2) && (rd1 == rs1_2)) ||
                       (reads_rs2(op2) && (rd1 == rs2_2)));
        pair_hazard = is_ctrl(op1) || (is_mem(op1) && is_mem(op2)) || raw_hazard;
        single      = fd_valid_q && pair_hazard && !w_miss;
    end

    // A flush must reload the fetch PCs even while downstream is stalled
    always_comb begin
        fd_valid_d = 1'b1;
        fd_pc1_d   = fd_pc1_q;
        fd_pc2_d   = fd_pc2_q;
        if (w_miss || !stall) begin
            fd_pc1_d = w_pc1;
            fd_pc2_d = w_pc2;
        end
    end

    always_comb begin
        iss_pc1_d  = iss_pc1_q;
        iss_pc2_d  = iss_pc2_q;
        iss_ir1_d  = iss_ir1_q;
        iss_ir2_d  = iss_ir2_q;
        iss_vld1_d = iss_vld1_q;
        iss_vld2_d = iss_vld2_q;
        n_single_d = n_single_q;
        n_dual_d   = n_dual_q;
        if (w_miss) begin
            iss_ir1_d  = NOP;
            iss_ir2_d  = NOP;
            iss_vld1_d = 1'b0;
            iss_vld2_d = 1'b0;
        end else if (!stall) begin
            iss_pc1_d  = fd_pc1_q;
            iss_pc2_d  = fd_pc2_q;
            iss_ir1_d  = instruction1;
            iss_vld1_d = fd_valid_q;
            if (single) begin
                // slot 2 is dropped here and refetched as the next slot 1
                iss_ir2_d  = NOP;
                iss_vld2_d = 1'b0;
            end else begin
                iss_ir2_d  = instruction2;
                iss_vld2_d = fd_valid_q;
            end
            if (fd_valid_q) begin
                if (single) begin
                    n_single_d = n_single_q + 16'd1;
                end else begin
                    n_dual_d = n_dual_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_valid_q <= 1'b0;
            fd_pc1_q   <= '0;
            fd_pc2_q   <= '0;
        end else begin
            fd_valid_q <= fd_valid_d;
            fd_pc1_q   <= fd_pc1_d;
            fd_pc2_q   <= fd_pc2_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_pc1_q  <= '0;
            iss_pc2_q  <= '0;
            iss_ir1_q  <= NOP;
            iss_ir2_q  <= NOP;
            iss_vld1_q <= 1'b0;
            iss_vld2_q <= 1'b0;
            n_single_q <= '0;
            n_dual_q   <= '0;
        end else begin
            iss_pc1_q  <= iss_pc1_d;
            iss_pc2_q  <= iss_pc2_d;
            iss_ir1_q  <= iss_ir1_d;
            iss_ir2_q  <= iss_ir2_d;
            iss_vld1_q <= iss_vld1_d;
            iss_vld2_q <= iss_vld2_d;
            n_single_q <= n_single_d;
            n_dual_q   <= n_dual_d;
        end
    end

    assign F_D_pc1        = fd_pc1_q;
    assign F_D_pc2        = fd_pc2_q;
    assign next_is_single = single;
    assign D_pc1          = iss_pc1_q;
    assign D_pc2          = iss_pc2_q;
    assign D_ir1          = iss_ir1_q;
    assign D_ir2          = iss_ir2_q;
    assign D_valid1       = iss_vld1_q;
    assign D_valid2       = iss_vld2_q;
    assign n_single       = n_single_q;
    assign n_dual         = n_dual_q;

endmodule

// File: tb/tb_stage_d_issue.sv
// Directed bench for stage_d_issue: pair hazard classes, stall/flush, async reset
// and issue-counter wrap, each against hand-encoded instruction words.
module tb_stage_d_issue;

    localparam logic [31:0] NOPW     = 32'h00000013;
    localparam logic [31:0] ADDI_X1  = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] ADDI_X2  = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] ADD_X3   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] SUB_X4   = 32'h40518233; // sub x4,x3,x5
    localparam logic [31:0] ADD_X5_0 = 32'h000002B3; // add x5,x0,x0
    localparam logic [31:0] ADDI_X3  = 32'h00100193; // addi x3,x0,1
    localparam logic [31:0] LUI_X4   = 32'h00018237; // lui x4 with rs1 field = 3
    localparam logic [31:0] ADDI_X4  = 32'h00300213; // addi x4,x0,3 (rs2 field = 3)
    localparam logic [31:0] ADD_X6   = 32'h00300333; // add x6,x0,x3
    localparam logic [31:0] BEQ      = 32'h00208463; // beq x1,x2,+8
    localparam logic [31:0] LW_X5    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] LW_X6    = 32'h00412303; // lw x6,4(x2)
    localparam logic [31:0] SW_X5    = 32'h0050A023; // sw x5,0(x1)
    localparam logic [31:0] JAL_X0   = 32'h0080006F; // jal x0,+8

    logic        clk;
    logic        reset;
    logic        stall;
    logic        w_miss;
    logic [14:0] w_pc1, w_pc2;
    logic [31:0] instruction1, instruction2;
    logic [14:0] F_D_pc1, F_D_pc2;
    logic        next_is_single;
    logic [14:0] D_pc1, D_pc2;
    logic [31:0] D_ir1, D_ir2;
    logic        D_valid1, D_valid2;
    logic [15:0] n_single, n_dual;

    int          vectors;
    int          miscompares;
    logic [15:0] exp_single;
    logic [15:0] exp_dual;

    stage_d_issue #(.NOP(32'h00000013)) dut (
        .clk(clk), .reset(reset), .stall(stall), .w_miss(w_miss),
        .w_pc1(w_pc1), .w_pc2(w_pc2),
        .instruction1(instruction1), .instruction2(instruction2),
        .F_D_pc1(F_D_pc1), .F_D_pc2(F_D_pc2), .next_is_single(next_is_single),
        .D_pc1(D_pc1), .D_pc2(D_pc2), .D_ir1(D_ir1), .D_ir2(D_ir2),
        .D_valid1(D_valid1), .D_valid2(D_valid2),
        .n_single(n_single), .n_dual(n_dual)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; w_miss = 1'b0;
        w_pc1 = 15'h0; w_pc2 = 15'h0;
        instruction1 = ADD_X3; instruction2 = SUB_X4;
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({F_D_pc1, F_D_pc2, D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual}
            !== {15'h0, 15'h0, 15'h0, 15'h0, NOPW, NOPW, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_state: got pc %h/%h ir %h/%h v %b%b cnt %h/%h", D_pc1, D_pc2,
                     D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual);
        end
        vectors++;
        if (next_is_single !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_nis: got %b expected 0", next_is_single);
        end
        step(); step();
        vectors++;
        if ({D_ir1, D_valid1, F_D_pc1} !== {NOPW, 1'b0, 15'h0}) begin
            miscompares++;
            $display("FAIL reset_held: got ir %h v %b fdpc %h", D_ir1, D_valid1, F_D_pc1);
        end
        @(negedge clk);
        reset = 1'b1;
        instruction1 = NOPW; instruction2 = NOPW;
        w_pc1 = 15'h0; w_pc2 = 15'h4;
        step();
        exp_single = 16'h0; exp_dual = 16'h0;
        vectors++;
        if ({D_valid1, D_valid2, n_single, n_dual, F_D_pc1, F_D_pc2}
            !== {1'b0, 1'b0, 16'h0, 16'h0, 15'h0, 15'h4}) begin
            miscompares++;
            $display("FAIL first_edge: got v %b%b cnt %h/%h fdpc %h/%h", D_valid1, D_valid2,
                     n_single, n_dual, F_D_pc1, F_D_pc2);
        end
    endtask

    // Loads the PCs into decode with a filler NOP pair, then presents the pair and issues it
    task automatic run_pair(input logic [14:0] p1, input logic [14:0] p2,
                            input logic [31:0] i1, input logic [31:0] i2,
                            input logic exp_nis, input string name);
        w_pc1 = p1; w_pc2 = p2;
        instruction1 = NOPW; instruction2 = NOPW;
        step();
        exp_dual++;
        instruction1 = i1; instruction2 = i2;
        #1;
        vectors++;
        if ({F_D_pc1, F_D_pc2, next_is_single} !== {p1, p2, exp_nis}) begin
            miscompares++;
            $display("FAIL %s_decode: got fdpc %h/%h nis %b expected %h/%h nis %b",
                     name, F_D_pc1, F_D_pc2, next_is_single, p1, p2, exp_nis);
        end
        step();
        if (exp_nis) exp_single++;
        else exp_dual++;
        vectors++;
        if ({D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2}
            !== {p1, p2, i1, (exp_nis ? NOPW : i2), 1'b1, !exp_nis}) begin
            miscompares++;
            $display("FAIL %s_issue: got pc %h/%h ir %h/%h v %b%b", name,
                     D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2);
        end
        vectors++;
        if ({n_single, n_dual} !== {exp_single, exp_dual}) begin
            miscompares++;
            $display("FAIL %s_counters: got %h/%h expected %h/%h", name,
                     n_single, n_dual, exp_single, exp_dual);
        end
        instruction1 = NOPW; instruction2 = NOPW;
    endtask

    task automatic test_pairs();
        run_pair(15'h000, 15'h004, ADDI_X1, ADDI_X2, 1'b0, "independent");
        run_pair(15'h008, 15'h00C, ADD_X3,  SUB_X4,  1'b1, "raw_rs1");
        run_pair(15'h010, 15'h014, NOPW,    ADD_X5_0, 1'b0, "x0_dest");
        run_pair(15'h018, 15'h01C, ADDI_X3, LUI_X4,  1'b0, "lui_no_rs1");
        run_pair(15'h020, 15'h024, ADDI_X3, ADDI_X4, 1'b0, "addi_no_rs2");
        run_pair(15'h028, 15'h02C, ADDI_X3, ADD_X6,  1'b1, "raw_rs2");
        run_pair(15'h030, 15'h034, BEQ,     ADDI_X2, 1'b1, "branch");
        run_pair(15'h038, 15'h03C, JAL_X0,  ADDI_X2, 1'b1, "jal");
        run_pair(15'h040, 15'h044, LW_X5,   LW_X6,   1'b1, "two_loads");
        run_pair(15'h048, 15'h04C, SW_X5,   LW_X6,   1'b1, "store_load");
    endtask

    task automatic test_stall();
        w_pc1 = 15'h050; w_pc2 = 15'h054;
        step();
        exp_dual++;
        instruction1 = ADDI_X1; instruction2 = ADDI_X2;
        w_pc1 = 15'h058; w_pc2 = 15'h05C;
        step();
        exp_dual++;
        instruction1 = ADD_X3; instruction2 = SUB_X4;
        stall = 1'b1;
        w_pc1 = 15'h080; w_pc2 = 15'h084;
        #1;
        vectors++;
        if (next_is_single !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_nis: got %b expected 1", next_is_single);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({F_D_pc1, F_D_pc2, D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual}
                !== {15'h058, 15'h05C, 15'h050, 15'h054, ADDI_X1, ADDI_X2, 1'b1, 1'b1,
                     exp_single, exp_dual}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got fdpc %h dpc %h ir %h/%h v %b%b cnt %h/%h", c,
                         F_D_pc1, D_pc1, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual);
            end
        end
        stall = 1'b0;
        step();
        exp_single++;
        vectors++;
        if ({F_D_pc1, F_D_pc2, D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual}
            !== {15'h080, 15'h084, 15'h058, 15'h05C, ADD_X3, NOPW, 1'b1, 1'b0,
                 exp_single, exp_dual}) begin
            miscompares++;
            $display("FAIL stall_release: got fdpc %h dpc %h ir %h/%h v %b%b cnt %h/%h",
                     F_D_pc1, D_pc1, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual);
        end
        instruction1 = NOPW; instruction2 = NOPW;
    endtask

    task automatic test_miss_with_stall();
        instruction1 = ADD_X3; instruction2 = SUB_X4;
        stall = 1'b1; w_miss = 1'b1;
        w_pc1 = 15'h100; w_pc2 = 15'h104;
        #1;
        vectors++;
        if (next_is_single !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_nis: got %b expected 0", next_is_single);
        end
        step();
        vectors++;
        if ({F_D_pc1, F_D_pc2, D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual}
            !== {15'h100, 15'h104, 15'h058, 15'h05C, NOPW, NOPW, 1'b0, 1'b0,
                 exp_single, exp_dual}) begin
            miscompares++;
            $display("FAIL miss_squash: got fdpc %h/%h dpc %h ir %h/%h v %b%b cnt %h/%h",
                     F_D_pc1, F_D_pc2, D_pc1, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual);
        end
        stall = 1'b0; w_miss = 1'b0;
        instruction1 = NOPW; instruction2 = NOPW;
    endtask

    task automatic test_reset_midstream();
        step();
        exp_dual++;
        vectors++;
        if ({D_valid1, D_valid2, D_pc1} !== {1'b1, 1'b1, 15'h100}) begin
            miscompares++;
            $display("FAIL pre_reset_valid: got v %b%b pc %h expected 11 pc 100",
                     D_valid1, D_valid2, D_pc1);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({F_D_pc1, F_D_pc2, D_pc1, D_pc2, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual,
             next_is_single}
            !== {15'h0, 15'h0, 15'h0, 15'h0, NOPW, NOPW, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got fdpc %h dpc %h ir %h/%h v %b%b cnt %h/%h nis %b",
                     F_D_pc1, D_pc1, D_ir1, D_ir2, D_valid1, D_valid2, n_single, n_dual,
                     next_is_single);
        end
        @(negedge clk);
        reset = 1'b1;
        w_pc1 = 15'h0; w_pc2 = 15'h4;
        step();
        exp_single = 16'h0; exp_dual = 16'h0;
        vectors++;
        if ({D_valid1, D_valid2, n_dual} !== {1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL post_reset_edge: got v %b%b n_dual %h expected 00 0000",
                     D_valid1, D_valid2, n_dual);
        end
    endtask

    task automatic test_counter_wrap();
        instruction1 = NOPW; instruction2 = NOPW;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
            exp_dual++;
        end
        #1;
        vectors++;
        if ({n_single, n_dual} !== {16'h0000, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL wrap_full: got %h/%h expected 0000/ffff", n_single, n_dual);
        end
        step();
        vectors++;
        if ({n_single, n_dual} !== {16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h/%h expected 0000/0000", n_single, n_dual);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_single  = 16'h0;
        exp_dual    = 16'h0;
        test_reset();
        test_pairs();
        test_stall();
        test_miss_with_stall();
        test_reset_midstream();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
